// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command-driven system controller:
// command codes, FSM state encoding and the fixed ALU operand addresses.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Operands of ALU_OP are staged in these register-file locations
    localparam int ADDR_OP_A = 0;
    localparam int ADDR_OP_B = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        FUN,
        ALU_WAIT,
        TX_REQ,
        TX_HOLD
    } state_e;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Transmit sequencer: buffers up to RES_WORDS words and hands them to the
// UART transmitter one at a time, least-significant word first, using the
// valid/busy handshake. Pulses done once the last word's busy period ends.
module sys_ctrl_tx_seq
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RES_WORDS = 2,
    parameter int CNT_W     = $clog2(RES_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [RES_WORDS*DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]            load_count,
    input  logic                        tx_busy,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_vld,
    output logic                        done
);

    state_e                      phase_q;
    logic [RES_WORDS*DATA_W-1:0] buf_q;
    logic [CNT_W-1:0]            idx_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            idx_next;

    assign idx_next = idx_q + CNT_W'(1);

    // Load the buffer, then present each word and hold valid until busy is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_data <= '0;
            tx_vld  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase_q)
                IDLE: begin
                    if (load) begin
                        buf_q   <= load_data;
                        cnt_q   <= load_count;
                        idx_q   <= '0;
                        phase_q <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (!tx_vld) begin
                        // tx_data only changes here, while valid is low
                        if (!tx_busy) begin
                            tx_data <= buf_q[int'(idx_q)*DATA_W +: DATA_W];
                            tx_vld  <= 1'b1;
                        end
                    end else if (tx_busy) begin
                        tx_vld  <= 1'b0;
                        phase_q <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    if (!tx_busy) begin
                        idx_q <= idx_next;
                        if (idx_next == cnt_q) begin
                            done    <= 1'b1;
                            phase_q <= IDLE;
                        end else begin
                            phase_q <= TX_REQ;
                        end
                    end
                end
                default: phase_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sys_ctrl_cmd.sv
// Command-driven system controller: decodes the UART RX byte stream into
// register-file accesses and ALU operations, gates the ALU clock, and
// returns read data / ALU results through the transmit sequencer.
module sys_ctrl_cmd
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int FUN_W     = 4,
    parameter int RES_WORDS = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_W-1:0]           RX_P_DATA,
    input  logic                        RX_D_VLD,
    output logic                        RF_WrEn,
    output logic                        RF_RdEn,
    output logic [ADDR_W-1:0]           RF_Address,
    output logic [DATA_W-1:0]           RF_WrData,
    input  logic [DATA_W-1:0]           RF_RdData,
    input  logic                        RF_RdData_VLD,
    output logic                        ALU_EN,
    output logic [FUN_W-1:0]            ALU_FUN,
    input  logic [RES_WORDS*DATA_W-1:0] ALU_OUT,
    input  logic                        ALU_OUT_VLD,
    output logic                        CLKG_EN,
    output logic [DATA_W-1:0]           TX_P_DATA,
    output logic                        TX_D_VLD,
    input  logic                        TX_BUSY,
    output logic                        CMD_ERR
);

    localparam int RES_W = RES_WORDS * DATA_W;
    localparam int CNT_W = $clog2(RES_WORDS + 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              tx_load;
    logic [RES_W-1:0]  tx_load_data;
    logic [CNT_W-1:0]  tx_load_count;
    logic              tx_done;

    // Command decoder and sequencing; strobes default low so each lasts one cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            RF_WrEn       <= 1'b0;
            RF_RdEn       <= 1'b0;
            RF_Address    <= '0;
            RF_WrData     <= '0;
            ALU_EN        <= 1'b0;
            ALU_FUN       <= '0;
            CLKG_EN       <= 1'b0;
            CMD_ERR       <= 1'b0;
            tx_load       <= 1'b0;
            tx_load_data  <= '0;
            tx_load_count <= '0;
        end else begin
            RF_WrEn <= 1'b0;
            RF_RdEn <= 1'b0;
            CMD_ERR <= 1'b0;
            tx_load <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            DATA_W'(CMD_RF_WR):   state_q <= WR_ADDR;
                            DATA_W'(CMD_RF_RD):   state_q <= RD_ADDR;
                            DATA_W'(CMD_ALU_OP):  state_q <= OP_A;
                            DATA_W'(CMD_ALU_NOP): state_q <= FUN;
                            default:              CMD_ERR <= 1'b1;
                        endcase
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q  <= RX_P_DATA[ADDR_W-1:0];
                        state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= addr_q;
                        RF_WrData  <= RX_P_DATA;
                        state_q    <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RdEn    <= 1'b1;
                        RF_Address <= RX_P_DATA[ADDR_W-1:0];
                        state_q    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    CMD_ERR <= RX_D_VLD;
                    if (RF_RdData_VLD) begin
                        tx_load       <= 1'b1;
                        tx_load_data  <= RES_W'(RF_RdData);
                        tx_load_count <= CNT_W'(1);
                        state_q       <= TX_REQ;
                    end
                end
                OP_A: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_W'(ADDR_OP_A);
                        RF_WrData  <= RX_P_DATA;
                        state_q    <= OP_B;
                    end
                end
                OP_B: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_W'(ADDR_OP_B);
                        RF_WrData  <= RX_P_DATA;
                        state_q    <= FUN;
                    end
                end
                FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[FUN_W-1:0];
                        ALU_EN  <= 1'b1;
                        CLKG_EN <= 1'b1;
                        state_q <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    CMD_ERR <= RX_D_VLD;
                    if (ALU_OUT_VLD) begin
                        ALU_EN        <= 1'b0;
                        tx_load       <= 1'b1;
                        tx_load_data  <= ALU_OUT;
                        tx_load_count <= CNT_W'(RES_WORDS);
                        state_q       <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    // Clock gate closes one cycle after ALU_EN, before any word goes out
                    CLKG_EN <= 1'b0;
                    CMD_ERR <= RX_D_VLD;
                    if (tx_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sys_ctrl_tx_seq #(
        .DATA_W    (DATA_W),
        .RES_WORDS (RES_WORDS),
        .CNT_W     (CNT_W)
    ) u_tx_seq (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (tx_load),
        .load_data  (tx_load_data),
        .load_count (tx_load_count),
        .tx_busy    (TX_BUSY),
        .tx_data    (TX_P_DATA),
        .tx_vld     (TX_D_VLD),
        .done       (tx_done)
    );

endmodule
